rv64_datapath: RTL and testbench
================================

# rv64_datapath

Single-cycle RV64I execute datapath: decodes one 32-bit instruction, computes the ALU result and branch condition, and performs the data-memory load/store with byte-lane alignment and sign/zero extension. Sits between instruction fetch/PC unit and the register file. Receives `pc`, `ins` and the register read data. Returns register addresses, write-back data and control-flow flags. Everything is combinational except a sticky halt flag.

## Interface
Parameters:
- `XLEN`, 64, datapath width (only 64 supported)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `ins`  in  32  current instruction
- `pc`  in  64  address of `ins`
- `rs1id`, `rs2id`, `rdid`  out  5 each  register indices `ins[19:15]`, `ins[24:20]`, `ins[11:7]`
- `rs1`, `rs2`  in  64  register file read data
- `imm`  out  64  sign-extended immediate (I/S/B/U/J per format, 0 for R-type)
- `rdwen`  out  1  register write enable
- `rd`  out  64  write-back data
- `brch`, `jal`, `jalr`  out  1  control-flow class to PC unit
- `zero`  out  1  branch condition true
- `mem_addr`  out  64  byte address (= ALU result)
- `mem_wen`  out  1  store this cycle
- `mem_wmask`  out  8  byte-lane strobe
- `mem_wdata`  out  64  lane-shifted store data
- `mem_rdata`  in  64  aligned doubleword at `{mem_addr[63:3],3'b0}`, combinational
- `illegal`  out  1  unrecognised encoding
- `halted`  out  1  sticky EBREAK flag

## Operation
- Supported instructions: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD, OP-IMM, OP, OP-IMM-32, OP-32, EBREAK.
- Operand B is `imm` or `rs2`. Operand A is `rs1`, or `pc` for AUIPC/JAL/JALR.
- Shift amount: 6 bits for 64-bit ops, 5 bits for W ops.
- W ops compute on the low 32 bits and sign-extend bit 31 into the result.
- JAL/JALR: `rd` = `pc`+4. The target address is computed by the PC unit.
- LUI: `rd` = `imm`.
- Branches: `zero` = comparison result (signed or unsigned per funct3). `rdwen` = 0.
- Loads: lane = `mem_addr[2:0]`. The bytes are extracted, then sign- or zero-extended; `rd` = load result.
- Stores: `mem_wdata` = `rs2` shifted left by 8×offset. `mem_wmask` = width mask shifted by offset. Bytes beyond lane 7 are dropped (no crossing). `rdwen` = 0.
- `rdwen` is forced to 0 when `rdid`==0.
- Illegal encoding: `illegal`=1. The instruction is executed as a NOP: no write, no store, no flow flags.
- EBREAK (0x00100073): NOP this cycle, and `halted` is set at the next edge.
- While `halted`=1, the following are all forced to 0: `rdwen`, `mem_wen`, `brch`, `jal`, `jalr`.

## Timing
- All outputs except `halted` are combinational from `ins`, `pc`, `rs1`, `rs2` and `mem_rdata`. Latency is 0.
- The store commits in the external memory at the rising `clk` edge where `mem_wen`=1.
- `halted` reset value is 0. `rst` has priority over setting `halted`.
- EBREAK in the same cycle as `rst`=1 leaves `halted`=0.
- Combinational outputs have no reset value; they follow their inputs during reset. `mem_wen` is forced to 0 while `rst`=1.

## Configuration
- `DPATH_MUL_EN` defined: MUL and MULW (funct7=0000001) decode legally.
  - MUL: `rd` = low 64 bits of the product.
  - MULW: `rd` = sign-extended low 32 bits of the 32×32 product.
- Undefined: MUL and MULW raise `illegal`, with NOP behaviour.

## Structure
- Package `rv64_pkg`:
  - opcode constants
  - ALU op enum
  - load/store width enum
  - operand-select enum
  - EBREAK constant
- Sub-module `rv64_decode` (pure combinational decoder producing the enums, `imm`, the flags and `illegal`). ALU, LSU alignment and the halt register stay in the top.

## Test plan
- ADDI x5,x0,-1 (0xFFF00293) → `rdwen`=1, `rdid`=5, `rd`=0xFFFF_FFFF_FFFF_FFFF.
- ADDIW with `rs1`=0x7FFF_FFFF, imm 1 → `rd`=0xFFFF_FFFF_8000_0000.
- SH x2 at `mem_addr`=0x1006 with `rs2`=0xABCD → `mem_wen`=1, `mem_wmask`=0xC0, `mem_wdata`=0xABCD_0000_0000_0000.
- LB at addr 0x1003 with `mem_rdata`=0x0000_0000_8000_0000 → `rd`=0xFFFF_FFFF_FFFF_FF80. LBU gives 0x80.
- BLTU with `rs1`=1, `rs2`=0xFFFF_FFFF_FFFF_FFFF → `zero`=1, `brch`=1, `rdwen`=0. BLT with the same operands → `zero`=0.
- EBREAK → `halted`=1 next cycle. A following SD gives `mem_wen`=0. Asserting `rst` then clears `halted`.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared definitions for the RV64I execute datapath: opcodes, decode enums
// and small helper functions.
package rv64_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {LS_B, LS_H, LS_W, LS_D} ls_width_e;

  typedef enum logic [1:0] {SRC_RS1_RS2, SRC_RS1_IMM, SRC_PC_IMM} src_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4} wb_sel_e;

  // Sign-extend a 32-bit W-op result to the full register width
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Base register/immediate ALU operation selected by funct3; alt picks SUB/SRA
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv64_decode.sv
// Combinational RV64I instruction decoder. Produces operation enums, the
// immediate, control flags and the illegal-encoding flag. Illegal encodings
// have every side-effect flag cleared so they execute as a NOP.
// Optional feature macro: DPATH_MUL_EN (MUL/MULW decode legally when defined).
module rv64_decode
  import rv64_pkg::*;
(
  input  logic [31:0] ins,
  output alu_op_e     alu_op,
  output logic        is_w,
  output src_sel_e    src_sel,
  output wb_sel_e     wb_sel,
  output ls_width_e   ls_width,
  output logic        ls_unsigned,
  output logic        load,
  output logic        store,
  output logic        brch,
  output logic        jal,
  output logic        jalr,
  output logic        wen,
  output logic        ebreak,
  output logic        illegal,
  output logic [63:0] imm
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;
  logic       ld, st, br, j, jr, w;

  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  // Opcode decode, legality check, then NOP-ing of illegal encodings
  always_comb begin
    alu_op      = ALU_ADD;
    is_w        = 1'b0;
    src_sel     = SRC_RS1_IMM;
    wb_sel      = WB_ALU;
    ls_width    = ls_width_e'(f3[1:0]);
    ls_unsigned = f3[2];
    ld = 1'b0; st = 1'b0; br = 1'b0; j = 1'b0; jr = 1'b0; w = 1'b0;
    ebreak      = 1'b0;
    bad         = 1'b0;
    imm         = '0;
    case (opc)
      OPC_LUI: begin
        imm = {{32{ins[31]}}, ins[31:12], 12'b0};
        alu_op = ALU_PASSB; w = 1'b1;
      end
      OPC_AUIPC: begin
        imm = {{32{ins[31]}}, ins[31:12], 12'b0};
        src_sel = SRC_PC_IMM; w = 1'b1;
      end
      OPC_JAL: begin
        imm = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        src_sel = SRC_PC_IMM; wb_sel = WB_PC4; w = 1'b1; j = 1'b1;
      end
      OPC_JALR: begin
        imm = {{52{ins[31]}}, ins[31:20]};
        src_sel = SRC_PC_IMM; wb_sel = WB_PC4; w = 1'b1; jr = 1'b1;
        bad = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        src_sel = SRC_RS1_RS2; alu_op = ALU_SUB; br = 1'b1;
        bad = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        imm = {{52{ins[31]}}, ins[31:20]};
        wb_sel = WB_LOAD; w = 1'b1; ld = 1'b1;
        bad = (f3 == 3'b111);
      end
      OPC_STORE: begin
        imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        st = 1'b1;
        bad = f3[2];
      end
      OPC_OPIMM: begin
        imm = {{52{ins[31]}}, ins[31:20]};
        w = 1'b1;
        alu_op = alu_from_f3(f3, (f3 == 3'b101) && ins[30]);
        if (f3 == 3'b001) bad = (ins[31:26] != 6'b0);
        if (f3 == 3'b101) bad = ({ins[31], ins[29:26]} != 5'b0);
      end
      OPC_OPIMM32: begin
        imm = {{52{ins[31]}}, ins[31:20]};
        w = 1'b1; is_w = 1'b1;
        alu_op = alu_from_f3(f3, ins[30]);
        case (f3)
          3'b000:  alu_op = ALU_ADD;
          3'b001:  bad = (f7 != 7'b0);
          3'b101:  bad = ({f7[6], f7[4:0]} != 6'b0);
          default: bad = 1'b1;
        endcase
      end
      OPC_OP, OPC_OP32: begin
        src_sel = SRC_RS1_RS2; w = 1'b1;
        is_w = (opc == OPC_OP32);
        alu_op = alu_from_f3(f3, 1'b0);
        if (f7 == 7'b0000000) begin
          if (is_w) bad = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          alu_op = alu_from_f3(f3, 1'b1);
        end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
`ifdef DPATH_MUL_EN
          alu_op = ALU_MUL;
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        imm = {{52{ins[31]}}, ins[31:20]};
        if (ins == INS_EBREAK) ebreak = 1'b1;
        else                   bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    illegal = bad;
    load    = ld & ~bad;
    store   = st & ~bad;
    brch    = br & ~bad;
    jal     = j  & ~bad;
    jalr    = jr & ~bad;
    wen     = w  & ~bad;
  end

endmodule

// File: rtl/rv64_datapath.sv
// Single-cycle RV64I execute datapath: ALU, branch compare, load/store lane
// alignment and the sticky EBREAK halt flag. Decode lives in rv64_decode.
// Optional feature macro: DPATH_MUL_EN (adds MUL/MULW).
module rv64_datapath
  import rv64_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1id,
  output logic [4:0]      rs2id,
  output logic [4:0]      rdid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic            rdwen,
  output logic [XLEN-1:0] rd,
  output logic            brch,
  output logic            jal,
  output logic            jalr,
  output logic            zero,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [7:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            illegal,
  output logic            halted
);

  alu_op_e   alu_op;
  src_sel_e  src_sel;
  wb_sel_e   wb_sel;
  ls_width_e ls_width;
  logic      is_w, ls_unsigned, dec_load, dec_store, dec_brch, dec_jal, dec_jalr;
  logic      dec_wen, dec_ebreak;

  rv64_decode u_decode (
    .ins(ins), .alu_op(alu_op), .is_w(is_w), .src_sel(src_sel), .wb_sel(wb_sel),
    .ls_width(ls_width), .ls_unsigned(ls_unsigned), .load(dec_load), .store(dec_store),
    .brch(dec_brch), .jal(dec_jal), .jalr(dec_jalr), .wen(dec_wen),
    .ebreak(dec_ebreak), .illegal(illegal), .imm(imm)
  );

  assign rs1id = ins[19:15];
  assign rs2id = ins[24:20];
  assign rdid  = ins[11:7];

  logic        [XLEN-1:0] op_a, op_b, alu_res, ld_shift, ld_res;
  logic signed [XLEN-1:0] op_a_s, op_b_s, rs1_s, rs2_s;
  logic        [31:0]     w_res;
  logic signed [31:0]     a32_s;
  logic        [2:0]      lane;
  logic        [7:0]      base_mask;

  assign op_a   = (src_sel == SRC_PC_IMM)  ? pc  : rs1;
  assign op_b   = (src_sel == SRC_RS1_RS2) ? rs2 : imm;
  assign op_a_s = op_a;
  assign op_b_s = op_b;
  assign rs1_s  = rs1;
  assign rs2_s  = rs2;
  assign a32_s  = op_a[31:0];

  // ALU: 64-bit ops use a 6-bit shift amount, W ops work on the low word
  always_comb begin
    w_res   = '0;
    alu_res = '0;
    if (is_w) begin
      case (alu_op)
        ALU_ADD: w_res = op_a[31:0] + op_b[31:0];
        ALU_SUB: w_res = op_a[31:0] - op_b[31:0];
        ALU_SLL: w_res = op_a[31:0] << op_b[4:0];
        ALU_SRL: w_res = op_a[31:0] >> op_b[4:0];
        ALU_SRA: w_res = a32_s >>> op_b[4:0];
`ifdef DPATH_MUL_EN
        ALU_MUL: w_res = op_a[31:0] * op_b[31:0];
`endif
        default: w_res = '0;
      endcase
      alu_res = sext32(w_res);
    end else begin
      case (alu_op)
        ALU_ADD:   alu_res = op_a + op_b;
        ALU_SUB:   alu_res = op_a - op_b;
        ALU_SLL:   alu_res = op_a << op_b[5:0];
        ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, op_a_s < op_b_s};
        ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
        ALU_XOR:   alu_res = op_a ^ op_b;
        ALU_SRL:   alu_res = op_a >> op_b[5:0];
        ALU_SRA:   alu_res = op_a_s >>> op_b[5:0];
        ALU_OR:    alu_res = op_a | op_b;
        ALU_AND:   alu_res = op_a & op_b;
`ifdef DPATH_MUL_EN
        ALU_MUL:   alu_res = op_a * op_b;
`endif
        ALU_PASSB: alu_res = op_b;
        default:   alu_res = '0;
      endcase
    end
  end

  assign mem_addr = alu_res;
  assign lane     = alu_res[2:0];
  assign ld_shift = mem_rdata >> {lane, 3'b000};

  // Load extraction with sign or zero extension
  always_comb begin
    ld_res = ld_shift;
    case (ls_width)
      LS_B: ld_res = ls_unsigned ? {56'b0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      LS_H: ld_res = ls_unsigned ? {48'b0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      LS_W: ld_res = ls_unsigned ? {32'b0, ld_shift[31:0]} : sext32(ld_shift[31:0]);
      default: ld_res = ld_shift;
    endcase
  end

  // Store lane strobe; bytes past lane 7 fall off the 8-bit mask
  always_comb begin
    case (ls_width)
      LS_B:    base_mask = 8'h01;
      LS_H:    base_mask = 8'h03;
      LS_W:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign mem_wmask = base_mask << lane;
  assign mem_wdata = rs2 << {lane, 3'b000};

  // Branch condition per funct3, only meaningful for decoded branches
  always_comb begin
    case (ins[14:12])
      3'b000:  zero = (rs1 == rs2);
      3'b001:  zero = (rs1 != rs2);
      3'b100:  zero = (rs1_s < rs2_s);
      3'b101:  zero = (rs1_s >= rs2_s);
      3'b110:  zero = (rs1 < rs2);
      3'b111:  zero = (rs1 >= rs2);
      default: zero = 1'b0;
    endcase
    zero = zero & dec_brch;
  end

  // Write-back selection
  always_comb begin
    case (wb_sel)
      WB_LOAD: rd = ld_res;
      WB_PC4:  rd = pc + 64'd4;
      default: rd = alu_res;
    endcase
  end

  assign rdwen   = dec_wen & (rdid != 5'd0) & ~halted;
  assign mem_wen = dec_store & ~halted & ~rst;
  assign brch    = dec_brch & ~halted;
  assign jal     = dec_jal  & ~halted;
  assign jalr    = dec_jalr & ~halted;

  // Sticky halt flag, set by EBREAK, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)             halted <= 1'b0;
    else if (dec_ebreak) halted <= 1'b1;
  end

endmodule

// File: tb/tb_rv64_datapath.sv
// Scoreboard bench for rv64_datapath: each driven instruction pushes its
// expected outputs, which are popped and compared once the cycle settles.
module tb_rv64_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic [63:0] pc, rs1, rs2, mem_rdata;
  logic [4:0]  rs1id, rs2id, rdid;
  logic [63:0] imm, rd, mem_addr, mem_wdata;
  logic        rdwen, brch, jal, jalr, zero, mem_wen, illegal, halted;
  logic [7:0]  mem_wmask;

  always #5 clk = ~clk;

  rv64_datapath #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .ins(ins), .pc(pc),
    .rs1id(rs1id), .rs2id(rs2id), .rdid(rdid), .rs1(rs1), .rs2(rs2),
    .imm(imm), .rdwen(rdwen), .rd(rd), .brch(brch), .jal(jal), .jalr(jalr),
    .zero(zero), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .illegal(illegal), .halted(halted)
  );

  typedef enum int {S_RD, S_RDWEN, S_RDID, S_ZERO, S_BRCH, S_JAL, S_WEN,
                    S_WMASK, S_WDATA, S_ADDR, S_HALT, S_ILL, S_IMM} sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] observe(input sig_e s);
    case (s)
      S_RD:    return rd;
      S_RDWEN: return {63'b0, rdwen};
      S_RDID:  return {59'b0, rdid};
      S_ZERO:  return {63'b0, zero};
      S_BRCH:  return {63'b0, brch};
      S_JAL:   return {63'b0, jal};
      S_WEN:   return {63'b0, mem_wen};
      S_WMASK: return {56'b0, mem_wmask};
      S_WDATA: return mem_wdata;
      S_ADDR:  return mem_addr;
      S_HALT:  return {63'b0, halted};
      S_ILL:   return {63'b0, illegal};
      default: return imm;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] i, input logic [63:0] p, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] md, input logic r);
    @(posedge clk);
    #1;
    ins = i; pc = p; rs1 = a; rs2 = b; mem_rdata = md; rst = r;
  endtask

  task automatic drain();
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] SD3 = 32'h0020_B1A3;

  initial begin
    rst = 1'b1; ins = NOP; pc = '0; rs1 = '0; rs2 = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    push_exp("reset_halted", S_HALT, 64'd0);
    drain();

    drive(32'hFFF0_0293, 64'h100, 64'd0, 64'd0, 64'd0, 1'b0);
    push_exp("addi_rd", S_RD, 64'hFFFF_FFFF_FFFF_FFFF);
    push_exp("addi_rdwen", S_RDWEN, 64'd1);
    push_exp("addi_rdid", S_RDID, 64'd5);
    push_exp("addi_ill", S_ILL, 64'd0);
    drain();

    drive(32'h0011_009B, 64'h104, 64'h7FFF_FFFF, 64'd0, 64'd0, 1'b0);
    push_exp("addiw_rd", S_RD, 64'hFFFF_FFFF_8000_0000);
    drain();

    drive(32'h0020_9323, 64'h108, 64'h1000, 64'hABCD, 64'd0, 1'b0);
    push_exp("sh_addr", S_ADDR, 64'h1006);
    push_exp("sh_wen", S_WEN, 64'd1);
    push_exp("sh_wmask", S_WMASK, 64'hC0);
    push_exp("sh_wdata", S_WDATA, 64'hABCD_0000_0000_0000);
    push_exp("sh_rdwen", S_RDWEN, 64'd0);
    drain();

    drive(32'h0030_8183, 64'h10C, 64'h1000, 64'd0, 64'h0000_0000_8000_0000, 1'b0);
    push_exp("lb_rd", S_RD, 64'hFFFF_FFFF_FFFF_FF80);
    push_exp("lb_wen", S_WEN, 64'd0);
    drain();

    drive(32'h0030_C183, 64'h110, 64'h1000, 64'd0, 64'h0000_0000_8000_0000, 1'b0);
    push_exp("lbu_rd", S_RD, 64'h80);
    drain();

    drive(32'h0020_E463, 64'h114, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    push_exp("bltu_zero", S_ZERO, 64'd1);
    push_exp("bltu_brch", S_BRCH, 64'd1);
    push_exp("bltu_rdwen", S_RDWEN, 64'd0);
    push_exp("bltu_imm", S_IMM, 64'd8);
    drain();

    drive(32'h0020_C463, 64'h118, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    push_exp("blt_zero", S_ZERO, 64'd0);
    drain();

    drive(32'h4020_D1B3, 64'h11C, 64'h8000_0000_0000_0000, 64'h44, 64'd0, 1'b0);
    push_exp("sra_rd", S_RD, 64'hF800_0000_0000_0000);
    drain();

    drive(SD3, 64'h120, 64'h1000, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    push_exp("sd_cross_wmask", S_WMASK, 64'hF8);
    push_exp("sd_cross_wdata", S_WDATA, 64'h4455_6677_8800_0000);
    drain();

    drive(32'h0000_00EF, 64'h2000, 64'd0, 64'd0, 64'd0, 1'b0);
    push_exp("jal_rd", S_RD, 64'h2004);
    push_exp("jal_flag", S_JAL, 64'd1);
    push_exp("jal_rdwen", S_RDWEN, 64'd1);
    drain();

    drive(32'h0050_0013, 64'h124, 64'd0, 64'd0, 64'd0, 1'b0);
    push_exp("x0_rdwen", S_RDWEN, 64'd0);
    drain();

    drive(32'h0220_81B3, 64'h128, 64'd6, 64'd7, 64'd0, 1'b0);
`ifdef DPATH_MUL_EN
    push_exp("mul_ill", S_ILL, 64'd0);
    push_exp("mul_rd", S_RD, 64'd42);
    push_exp("mul_rdwen", S_RDWEN, 64'd1);
`else
    push_exp("mul_ill", S_ILL, 64'd1);
    push_exp("mul_rdwen", S_RDWEN, 64'd0);
`endif
    drain();

    drive(EBRK, 64'h12C, 64'd0, 64'd0, 64'd0, 1'b0);
    push_exp("ebreak_halt_now", S_HALT, 64'd0);
    push_exp("ebreak_ill", S_ILL, 64'd0);
    push_exp("ebreak_rdwen", S_RDWEN, 64'd0);
    drain();

    drive(SD3, 64'h130, 64'h1000, 64'd1, 64'd0, 1'b0);
    push_exp("halt_set", S_HALT, 64'd1);
    push_exp("halt_sd_wen", S_WEN, 64'd0);
    drain();

    drive(32'h0000_00EF, 64'h134, 64'd0, 64'd0, 64'd0, 1'b0);
    push_exp("halt_jal", S_JAL, 64'd0);
    push_exp("halt_rdwen", S_RDWEN, 64'd0);
    drain();

    drive(SD3, 64'h138, 64'h1000, 64'd1, 64'd0, 1'b1);
    push_exp("rst_sd_wen", S_WEN, 64'd0);
    push_exp("rst_halt_before_edge", S_HALT, 64'd1);
    drain();

    drive(NOP, 64'h13C, 64'd0, 64'd0, 64'd0, 1'b0);
    push_exp("rst_clears_halt", S_HALT, 64'd0);
    drain();

    drive(EBRK, 64'h140, 64'd0, 64'd0, 64'd0, 1'b1);
    drain();
    drive(SD3, 64'h144, 64'h1000, 64'd1, 64'd0, 1'b0);
    push_exp("ebreak_in_rst_halt", S_HALT, 64'd0);
    push_exp("post_rst_sd_wen", S_WEN, 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
